// File: rtl/code_lock_pkg.sv
// Shared definitions for the keypad code lock.
//   KEY_CANCEL / KEY_SET : special key values on key_code
//   state_e              : controller states
//   is_digit()           : true for key values 0-9
package code_lock_pkg;

  localparam int unsigned KEY_CANCEL = 32'hD;
  localparam int unsigned KEY_SET    = 32'hE;

  typedef enum logic [1:0] {
    LOCKED,
    UNLOCKED,
    PROGRAM,
    LOCKOUT
  } state_e;

  function automatic logic is_digit(input int unsigned key);
    return key <= 32'd9;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the unlock hold and lockout periods.
//   clk_i      : clock
//   rst_i      : synchronous reset, active-high
//   load_i     : load load_val_i (takes priority over clear_i)
//   load_val_i : period in cycles; done_o fires in the last cycle of the period
//   clear_i    : abandon the running period
//   done_o     : high in the final counted cycle (count == 1)
module lock_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             clear_i,
  output logic             done_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (clear_i) begin
      cnt_d = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A loaded value N yields exactly N cycles before the owner leaves its state.
  assign done_o = (cnt_q == Width'(1));

endmodule

// File: rtl/code_lock_ctrl.sv
// Parametrised keypad code lock controller.
//   clk       : clock
//   rst       : synchronous reset, active-high
//   key_valid : one-cycle key strobe
//   key_code  : key value (0-9 digits, KEY_CANCEL, KEY_SET)
//   unlocked  : lock released (registered)
//   lockout   : lockout active (registered)
//   prog_mode : new code being entered (registered)
//   fail_cnt  : consecutive failed attempts, saturating at MAX_FAILS
// Build option: define PROG_CONFIRM_EN to require the new code to be entered twice.
module code_lock_ctrl
  import code_lock_pkg::*;
#(
  parameter int unsigned CODE_LEN       = 4,
  parameter int unsigned DIGIT_W        = 4,
  parameter int unsigned UNLOCK_CYCLES  = 10_000_000,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 50_000_000,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_code,
  output logic               unlocked,
  output logic               lockout,
  output logic               prog_mode,
  output logic [3:0]         fail_cnt
);

  localparam int unsigned CodeW  = CODE_LEN * DIGIT_W;
  localparam int unsigned IdxW   = $clog2(CODE_LEN);
  localparam int unsigned PosW   = $clog2(CodeW);
  localparam int unsigned TmrMax = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES
                                                                    : LOCKOUT_CYCLES;
  localparam int unsigned TmrW   = $clog2(TmrMax + 1);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(CODE_LEN - 1);
  localparam logic [3:0]      MaxFails = 4'(MAX_FAILS);

  state_e             state_q, state_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic               mm_q, mm_d;
  logic [3:0]         fail_q, fail_d;
  logic [CodeW-1:0]   code_q, code_d;
  logic [CodeW-1:0]   shadow_q, shadow_d;
`ifdef PROG_CONFIRM_EN
  logic               confirm_q, confirm_d;  // second (confirming) entry in progress
  logic [DIGIT_W-1:0] shadow_digit;
`endif

  logic [31:0]        key_word;
  logic               key_digit, key_cancel, key_set, last;
  logic [PosW-1:0]    pos;
  logic [DIGIT_W-1:0] code_digit;
  logic               cur_mm;
  logic [3:0]         fail_inc;
  logic               tmr_load, tmr_clear, tmr_done;
  logic [TmrW-1:0]    tmr_val;

  assign key_word   = 32'(key_code);
  assign key_digit  = is_digit(key_word);
  assign key_cancel = (key_word == KEY_CANCEL);
  assign key_set    = (key_word == KEY_SET);
  assign last       = (idx_q == LastIdx);
  // Digit 0 lives in the most significant slot.
  assign pos        = PosW'((CODE_LEN - 1 - 32'(idx_q)) * DIGIT_W);
  assign code_digit = code_q[pos +: DIGIT_W];
  // Non-digit keys always count as a wrong digit, even if the stored code holds that value.
  assign cur_mm     = mm_q | ~key_digit | (key_code != code_digit);
  assign fail_inc   = (fail_q >= MaxFails) ? MaxFails : fail_q + 4'd1;
`ifdef PROG_CONFIRM_EN
  assign shadow_digit = shadow_q[pos +: DIGIT_W];
`endif

  lock_timer #(
    .Width(TmrW)
  ) u_timer (
    .clk_i     (clk),
    .rst_i     (rst),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .clear_i   (tmr_clear),
    .done_o    (tmr_done)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mm_d      = mm_q;
    fail_d    = fail_q;
    code_d    = code_q;
    shadow_d  = shadow_q;
`ifdef PROG_CONFIRM_EN
    confirm_d = confirm_q;
`endif
    tmr_load  = 1'b0;
    tmr_val   = '0;
    tmr_clear = 1'b0;

    unique case (state_q)
      LOCKED: begin
        if (key_valid) begin
          if (key_cancel) begin
            idx_d = '0;
            mm_d  = 1'b0;
          end else if (!key_set) begin
            if (last) begin
              idx_d = '0;
              mm_d  = 1'b0;
              if (!cur_mm) begin
                state_d  = UNLOCKED;
                fail_d   = 4'd0;
                tmr_load = 1'b1;
                tmr_val  = TmrW'(UNLOCK_CYCLES);
              end else begin
                fail_d = fail_inc;
                if (fail_inc == MaxFails) begin
                  state_d  = LOCKOUT;
                  tmr_load = 1'b1;
                  tmr_val  = TmrW'(LOCKOUT_CYCLES);
                end
              end
            end else begin
              idx_d = idx_q + 1'b1;
              mm_d  = cur_mm;
            end
          end
        end
      end

      UNLOCKED: begin
        // Expiry wins over a simultaneous key.
        if (tmr_done) begin
          state_d = LOCKED;
        end else if (key_valid) begin
          if (key_cancel) begin
            state_d   = LOCKED;
            tmr_clear = 1'b1;
          end else if (key_set) begin
            state_d   = PROGRAM;
            tmr_clear = 1'b1;
            idx_d     = '0;
            mm_d      = 1'b0;
`ifdef PROG_CONFIRM_EN
            confirm_d = 1'b0;
`endif
          end
        end
      end

      PROGRAM: begin
        if (key_valid) begin
          if (key_set) begin
            idx_d = '0;
            mm_d  = 1'b0;
`ifdef PROG_CONFIRM_EN
            confirm_d = 1'b0;
`endif
          end else if (key_digit) begin
`ifdef PROG_CONFIRM_EN
            if (!confirm_q) begin
              shadow_d[pos +: DIGIT_W] = key_code;
              if (last) begin
                idx_d     = '0;
                confirm_d = 1'b1;
              end else begin
                idx_d = idx_q + 1'b1;
              end
            end else if (last) begin
              if (!(mm_q | (key_code != shadow_digit))) begin
                code_d = shadow_q;
              end
              state_d   = LOCKED;
              idx_d     = '0;
              mm_d      = 1'b0;
              confirm_d = 1'b0;
            end else begin
              idx_d = idx_q + 1'b1;
              mm_d  = mm_q | (key_code != shadow_digit);
            end
`else
            shadow_d[pos +: DIGIT_W] = key_code;
            if (last) begin
              code_d  = shadow_d;  // whole code replaced in one cycle
              state_d = LOCKED;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
`endif
          end else begin
            // CANCEL or any other non-digit abandons the new code.
            state_d = LOCKED;
            idx_d   = '0;
            mm_d    = 1'b0;
`ifdef PROG_CONFIRM_EN
            confirm_d = 1'b0;
`endif
          end
        end
      end

      LOCKOUT: begin
        if (tmr_done) begin
          state_d = LOCKED;
          fail_d  = 4'd0;
        end
      end

      default: state_d = LOCKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LOCKED;
      idx_q     <= '0;
      mm_q      <= 1'b0;
      fail_q    <= 4'd0;
      code_q    <= DEFAULT_CODE;
      shadow_q  <= '0;
      unlocked  <= 1'b0;
      lockout   <= 1'b0;
      prog_mode <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      mm_q      <= mm_d;
      fail_q    <= fail_d;
      code_q    <= code_d;
      shadow_q  <= shadow_d;
      unlocked  <= (state_d == UNLOCKED);
      lockout   <= (state_d == LOCKOUT);
      prog_mode <= (state_d == PROGRAM);
    end
  end

`ifdef PROG_CONFIRM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      confirm_q <= 1'b0;
    end else begin
      confirm_q <= confirm_d;
    end
  end
`endif

  assign fail_cnt = fail_q;

endmodule

// File: tb/tb_code_lock_ctrl.sv
module tb_code_lock_ctrl;

  localparam logic [3:0] KCAN = 4'hD;
  localparam logic [3:0] KSET = 4'hE;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       unlocked, lockout, prog_mode;
  logic [3:0] fail_cnt;

  int errors = 0;
  int checks = 0;

  code_lock_ctrl #(
    .CODE_LEN      (4),
    .DIGIT_W       (4),
    .UNLOCK_CYCLES (8),
    .MAX_FAILS     (3),
    .LOCKOUT_CYCLES(16),
    .DEFAULT_CODE  (16'h0000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_valid(key_valid),
    .key_code (key_code),
    .unlocked (unlocked),
    .lockout  (lockout),
    .prog_mode(prog_mode),
    .fail_cnt (fail_cnt)
  );

  always #5 clk = ~clk;

  // All stimulus changes and samples happen 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    step();
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic enter4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic [3:0] d);
    press(a); press(b); press(c); press(d);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    checks++; if ({unlocked, lockout, prog_mode} !== 3'b000) begin errors++;
      $display("FAIL reset_outputs: got %b expected 000", {unlocked, lockout, prog_mode}); end
    checks++; if (fail_cnt !== 4'd0) begin errors++;
      $display("FAIL reset_fail_cnt: got %0d expected 0", fail_cnt); end
  endtask

  task automatic test_unlock();
    int n;
    enter4(0, 0, 0, 0);
    checks++; if (unlocked !== 1'b1) begin errors++;
      $display("FAIL unlock_rise: unlocked=%b expected 1", unlocked); end
    n = 0;
    while (unlocked === 1'b1 && n < 50) begin n++; step(); end
    checks++; if (n != 8) begin errors++;
      $display("FAIL unlock_hold: high for %0d cycles expected 8", n); end
  endtask

  task automatic test_wrong();
    press(0); press(5);
    checks++; if (unlocked !== 1'b0) begin errors++;
      $display("FAIL wrong_early: unlocked=%b expected 0", unlocked); end
    press(0); press(0);
    checks++; if (unlocked !== 1'b0) begin errors++;
      $display("FAIL wrong_last: unlocked=%b expected 0", unlocked); end
    checks++; if (fail_cnt !== 4'd1) begin errors++;
      $display("FAIL wrong_fail_cnt: got %0d expected 1", fail_cnt); end
  endtask

  task automatic test_cancel();
    press(0); press(5); press(KCAN);
    checks++; if (fail_cnt !== 4'd1) begin errors++;
      $display("FAIL cancel_no_count: fail_cnt=%0d expected 1", fail_cnt); end
    enter4(0, 0, 0, 0);
    checks++; if (unlocked !== 1'b1 || fail_cnt !== 4'd0) begin errors++;
      $display("FAIL cancel_then_unlock: unlocked=%b fail_cnt=%0d expected 1/0",
               unlocked, fail_cnt); end
    press(KCAN);
    checks++; if (unlocked !== 1'b0) begin errors++;
      $display("FAIL cancel_relock: unlocked=%b expected 0", unlocked); end
  endtask

  task automatic test_lockout();
    int  n;
    bit  saw_unlock;
    enter4(1, 1, 1, 1);
    enter4(1, 1, 1, 1);
    checks++; if (fail_cnt !== 4'd2 || lockout !== 1'b0) begin errors++;
      $display("FAIL lockout_two: fail_cnt=%0d lockout=%b expected 2/0", fail_cnt, lockout); end
    enter4(1, 1, 1, 1);
    checks++; if (fail_cnt !== 4'd3 || lockout !== 1'b1) begin errors++;
      $display("FAIL lockout_enter: fail_cnt=%0d lockout=%b expected 3/1", fail_cnt, lockout); end
    // Feed the correct code during the first lockout cycles; it must be ignored.
    n = 0;
    saw_unlock = 1'b0;
    while (lockout === 1'b1 && n < 100) begin
      key_valid = (n < 4);
      key_code  = 4'h0;
      n++;
      step();
      if (unlocked === 1'b1) saw_unlock = 1'b1;
    end
    key_valid = 1'b0;
    checks++; if (n != 16) begin errors++;
      $display("FAIL lockout_len: high for %0d cycles expected 16", n); end
    checks++; if (saw_unlock) begin errors++;
      $display("FAIL lockout_keys_ignored: unlocked seen=1 expected 0"); end
    checks++; if (fail_cnt !== 4'd0) begin errors++;
      $display("FAIL lockout_clear: fail_cnt=%0d expected 0", fail_cnt); end
    enter4(0, 0, 0, 0);
    checks++; if (unlocked !== 1'b1) begin errors++;
      $display("FAIL lockout_after_unlock: unlocked=%b expected 1", unlocked); end
    press(KCAN);
  endtask

  task automatic test_program();
    enter4(0, 0, 0, 0);
    press(KSET);
    checks++; if (prog_mode !== 1'b1 || unlocked !== 1'b0) begin errors++;
      $display("FAIL prog_enter: prog_mode=%b unlocked=%b expected 1/0", prog_mode, unlocked); end
`ifdef PROG_CONFIRM_EN
    enter4(1, 2, 3, 4);
`endif
    press(1); press(2); press(3);
    checks++; if (prog_mode !== 1'b1) begin errors++;
      $display("FAIL prog_midway: prog_mode=%b expected 1", prog_mode); end
    press(4);
    checks++; if (prog_mode !== 1'b0 || unlocked !== 1'b0) begin errors++;
      $display("FAIL prog_commit: prog_mode=%b unlocked=%b expected 0/0", prog_mode, unlocked); end
    enter4(0, 0, 0, 0);
    checks++; if (unlocked !== 1'b0 || fail_cnt !== 4'd1) begin errors++;
      $display("FAIL prog_old_rejected: unlocked=%b fail_cnt=%0d expected 0/1",
               unlocked, fail_cnt); end
    enter4(1, 2, 3, 4);
    checks++; if (unlocked !== 1'b1 || fail_cnt !== 4'd0) begin errors++;
      $display("FAIL prog_new_accepted: unlocked=%b fail_cnt=%0d expected 1/0",
               unlocked, fail_cnt); end
    press(KCAN);
  endtask

  task automatic test_reset_mid();
    enter4(1, 2, 3, 4);
    press(KSET); press(5); press(6);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if ({unlocked, lockout, prog_mode} !== 3'b000 || fail_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %b/%0d expected 000/0",
               {unlocked, lockout, prog_mode}, fail_cnt); end
    enter4(0, 0, 0, 0);
    checks++; if (unlocked !== 1'b1) begin errors++;
      $display("FAIL reset_default_code: unlocked=%b expected 1", unlocked); end
    press(KCAN);
  endtask

  task automatic test_prog_abort();
    enter4(0, 0, 0, 0);
    press(KSET); press(1); press(2); press(KCAN);
    checks++; if (prog_mode !== 1'b0 || unlocked !== 1'b0) begin errors++;
      $display("FAIL prog_cancel: prog_mode=%b unlocked=%b expected 0/0", prog_mode, unlocked); end
    enter4(0, 0, 0, 0);
    checks++; if (unlocked !== 1'b1) begin errors++;
      $display("FAIL prog_cancel_old_code: unlocked=%b expected 1", unlocked); end
    press(KSET); press(4'hA);
    checks++; if (prog_mode !== 1'b0) begin errors++;
      $display("FAIL prog_nondigit_abort: prog_mode=%b expected 0", prog_mode); end
    enter4(0, 0, 0, 0);
    checks++; if (unlocked !== 1'b1) begin errors++;
      $display("FAIL prog_nondigit_old_code: unlocked=%b expected 1", unlocked); end
    press(KCAN);
`ifdef PROG_CONFIRM_EN
    enter4(0, 0, 0, 0);
    press(KSET);
    enter4(1, 2, 3, 4);
    enter4(1, 2, 3, 5);
    checks++; if (prog_mode !== 1'b0) begin errors++;
      $display("FAIL confirm_mismatch: prog_mode=%b expected 0", prog_mode); end
    enter4(0, 0, 0, 0);
    checks++; if (unlocked !== 1'b1) begin errors++;
      $display("FAIL confirm_old_code: unlocked=%b expected 1", unlocked); end
    press(KCAN);
`endif
  endtask

  task automatic test_expiry_collision();
    enter4(0, 0, 0, 0);
    repeat (7) step();
    checks++; if (unlocked !== 1'b1) begin errors++;
      $display("FAIL expiry_last_cycle: unlocked=%b expected 1", unlocked); end
    press(KSET);
    checks++; if (unlocked !== 1'b0 || prog_mode !== 1'b0) begin errors++;
      $display("FAIL expiry_vs_set: unlocked=%b prog_mode=%b expected 0/0", unlocked, prog_mode); end
    step();
    checks++; if (prog_mode !== 1'b0) begin errors++;
      $display("FAIL expiry_prog_stays_low: prog_mode=%b expected 0", prog_mode); end
  endtask

  task automatic test_back_to_back();
    enter4(0, 0, 4'hA, 0);
    checks++; if (unlocked !== 1'b0 || fail_cnt !== 4'd1) begin errors++;
      $display("FAIL b2b_nondigit_fail: unlocked=%b fail_cnt=%0d expected 0/1",
               unlocked, fail_cnt); end
    enter4(0, 0, 0, 0);
    checks++; if (unlocked !== 1'b1 || fail_cnt !== 4'd0) begin errors++;
      $display("FAIL b2b_unlock: unlocked=%b fail_cnt=%0d expected 1/0", unlocked, fail_cnt); end
    press(7);
    checks++; if (unlocked !== 1'b1) begin errors++;
      $display("FAIL b2b_digit_ignored: unlocked=%b expected 1", unlocked); end
    press(KCAN);
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_wrong();
    test_cancel();
    test_lockout();
    test_program();
    test_reset_mid();
    test_prog_abort();
    test_expiry_collision();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
